apb_cfg_arbiter: RTL
====================

APB_CFG_ARBITER -- requirements
Module: apb_cfg_arbiter

Interface
REQ-001 The block SHALL have parameter ADDRESS_BUS_WIDTH, default 16, APB address width.
REQ-002 The block SHALL have parameter DATA_BUS_WIDTH, default 32, APB data width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ACCESS-phase wait cycles (range 2..255).
REQ-004 The block SHALL have port pclk, input, 1, clock; all logic on rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-006 The block SHALL have port req_i, input, 2, per-requester transfer request, held high until done.
REQ-007 The block SHALL have port write_i, input, 2, per-requester direction (1 = write).
REQ-008 The block SHALL have ports addr0_i and addr1_i, input, ADDRESS_BUS_WIDTH, requester 0 and 1 target address.
REQ-009 The block SHALL have ports wdata0_i and wdata1_i, input, DATA_BUS_WIDTH, requester 0 and 1 write data.
REQ-010 The block SHALL have port done_o, output, 2, one-cycle completion pulse to the granted requester.
REQ-011 The block SHALL have port err_o, output, 1, completion status, valid while any done_o bit is high.
REQ-012 The block SHALL have port rdata_o, output, DATA_BUS_WIDTH, read data of the last completed read.
REQ-013 The block SHALL have ports psel, penable, pwrite, outputs, 1 each, APB master controls.
REQ-014 The block SHALL have ports paddr (ADDRESS_BUS_WIDTH) and pwdata (DATA_BUS_WIDTH), outputs, APB address and write data.
REQ-015 The block SHALL have ports pready, pslverr (1 each) and prdata (DATA_BUS_WIDTH), inputs, APB slave response.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, ACCESS; IDLE->SETUP when any req_i bit high, SETUP->ACCESS unconditionally, ACCESS->IDLE on completion.
REQ-017 On IDLE exit the block SHALL latch grant, address, write data and direction of the winner; later changes to requester inputs SHALL not affect the transfer.
REQ-018 Arbitration SHALL be round-robin: a single request wins; with both requesting, the requester not served last wins.
REQ-019 In SETUP: psel=1, penable=0; in ACCESS: psel=1, penable=1; in IDLE: psel=0, penable=0.
REQ-020 paddr, pwdata, pwrite SHALL hold latched values during SETUP and ACCESS, and be 0 in IDLE.
REQ-021 pready SHALL count as ready only when exactly 1'b1; 0, z and x SHALL mean wait-state.
REQ-022 On ACCESS with pready=1: done_o[grant]=1 for one cycle, err_o = pslverr at that edge (z/x treated as 0), return to IDLE.
REQ-023 For completed reads rdata_o SHALL load prdata; for writes rdata_o SHALL hold; rdata_o SHALL hold until the next completed read.
REQ-024 Minimum transfer: req_i sampled at edge N, SETUP cycle N+1, ACCESS cycle N+2, done_o pulse at cycle N+3 when pready=1 in ACCESS; back-to-back transfers SHALL have one IDLE cycle between them.
REQ-025 A req_i drop mid-transfer SHALL not abort; the transfer completes and done_o still pulses.
REQ-026 A requester SHALL not be re-granted in the IDLE cycle coinciding with its own done_o pulse.

Reset
REQ-027 When reset=0: FSM IDLE, all outputs 0, rdata_o 0, round-robin pointer set so requester 0 wins the first tie, timeout counter 0.
REQ-028 Reset asserted mid-transfer SHALL abort it immediately with no done_o pulse.

Configuration
REQ-029 With macro APB_ACCESS_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles; if TIMEOUT_CYCLES elapse without pready=1, the block SHALL end the transfer with done_o[grant]=1, err_o=1, rdata_o unchanged, and return to IDLE.
REQ-030 Without APB_ACCESS_TIMEOUT_EN, no counter SHALL be built and ACCESS SHALL wait indefinitely for pready=1.

Verification
REQ-031 Requester 0 write addr 0x0000 data 0xDEADBEEF, pready=1 at once -> psel 2 cycles, penable 1 cycle, paddr=0x0000, pwdata=0xDEADBEEF, done_o=01, err_o=0.
REQ-032 Requester 1 read addr 0x0004, slave prdata 0xAABBCCDD after 3 wait states -> done_o=10 on 4th ACCESS cycle, rdata_o=0xAABBCCDD.
REQ-033 Both requesting continuously after reset -> grant sequence 0,1,0,1 with one IDLE cycle between transfers.
REQ-034 pready=z (no slave selected) with APB_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=16 -> done_o pulse after 16 ACCESS cycles, err_o=1; without macro, psel stays high.
REQ-035 Slave returns pslverr=1 with pready=1 -> err_o=1 with done_o; reset=0 pulsed during ACCESS -> psel=0 immediately, no done_o.

Source files
------------

// File: rtl/apb_cfg_arbiter.sv
// Two-requester round-robin APB master for configuration register accesses.
// Optional ACCESS-phase timeout is built only when APB_ACCESS_TIMEOUT_EN is defined.
module apb_cfg_arbiter #(
   parameter int ADDRESS_BUS_WIDTH = 16,
   parameter int DATA_BUS_WIDTH    = 32,
   parameter int TIMEOUT_CYCLES    = 16
) (
   input  logic                         pclk,
   input  logic                         reset,
   input  logic [1:0]                   req_i,
   input  logic [1:0]                   write_i,
   input  logic [ADDRESS_BUS_WIDTH-1:0] addr0_i,
   input  logic [ADDRESS_BUS_WIDTH-1:0] addr1_i,
   input  logic [DATA_BUS_WIDTH-1:0]    wdata0_i,
   input  logic [DATA_BUS_WIDTH-1:0]    wdata1_i,
   output logic [1:0]                   done_o,
   output logic                         err_o,
   output logic [DATA_BUS_WIDTH-1:0]    rdata_o,
   output logic                         psel,
   output logic                         penable,
   output logic                         pwrite,
   output logic [ADDRESS_BUS_WIDTH-1:0] paddr,
   output logic [DATA_BUS_WIDTH-1:0]    pwdata,
   input  logic                         pready,
   input  logic                         pslverr,
   input  logic [DATA_BUS_WIDTH-1:0]    prdata
);

   localparam logic [ADDRESS_BUS_WIDTH-1:0] ADDR_ZERO = {ADDRESS_BUS_WIDTH{1'b0}};
   localparam logic [DATA_BUS_WIDTH-1:0]    DATA_ZERO = {DATA_BUS_WIDTH{1'b0}};

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10
   } state_t;

   state_t                         state_r;
   state_t                         state_s;
   logic                           grant_r;
   logic                           grant_s;
   logic                           last_r;
   logic                           last_s;
   logic [1:0]                     elig_s;
   logic                           any_req_s;
   logic                           win_s;
   logic                           ready_s;
   logic                           slverr_s;
   logic                           timeout_s;
   logic                           finish_s;
   logic                           psel_s;
   logic                           penable_s;
   logic                           pwrite_s;
   logic [ADDRESS_BUS_WIDTH-1:0]   paddr_s;
   logic [DATA_BUS_WIDTH-1:0]      pwdata_s;
   logic [DATA_BUS_WIDTH-1:0]      rdata_s;
   logic [1:0]                     done_s;
   logic                           err_s;

   // Slave response decode: only a clean logic 1 counts as ready or error.
   always_comb begin
      ready_s  = 1'b0;
      slverr_s = 1'b0;
      if (pready == 1'b1) begin
         ready_s = 1'b1;
      end else begin
         ready_s = 1'b0;
      end
      if (pslverr == 1'b1) begin
         slverr_s = 1'b1;
      end else begin
         slverr_s = 1'b0;
      end
   end

   // Round-robin pick; the requester being told done this cycle sits out.
   always_comb begin
      elig_s    = req_i & ~done_o;
      any_req_s = |elig_s;
      case (elig_s)
         2'b01:   win_s = 1'b0;
         2'b10:   win_s = 1'b1;
         2'b11:   win_s = ~last_r;
         default: win_s = 1'b0;
      endcase
   end

`ifdef APB_ACCESS_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] tcnt_r;

   // Counts completed ACCESS cycles of the current transfer.
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         tcnt_r <= 8'd0;
      end else if ((state_r == ACCESS) && !finish_s) begin
         tcnt_r <= tcnt_r + 8'd1;
      end else begin
         tcnt_r <= 8'd0;
      end
   end

   // Timeout fires in the last permitted ACCESS cycle if the slave is still busy.
   always_comb begin
      if ((state_r == ACCESS) && !ready_s && (tcnt_r == TIMEOUT_LAST)) begin
         timeout_s = 1'b1;
      end else begin
         timeout_s = 1'b0;
      end
   end
`else
   assign timeout_s = 1'b0;
`endif

   // Transfer termination: slave ready or timeout.
   always_comb begin
      if ((state_r == ACCESS) && (ready_s || timeout_s)) begin
         finish_s = 1'b1;
      end else begin
         finish_s = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (any_req_s) begin
               state_s = SETUP;
            end else begin
               state_s = IDLE;
            end
         end
         SETUP: state_s = ACCESS;
         ACCESS: begin
            if (finish_s) begin
               state_s = IDLE;
            end else begin
               state_s = ACCESS;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Next values of the registered outputs; the APB bus registers double as the transfer latch.
   always_comb begin
      psel_s    = psel;
      penable_s = penable;
      pwrite_s  = pwrite;
      paddr_s   = paddr;
      pwdata_s  = pwdata;
      rdata_s   = rdata_o;
      done_s    = 2'b00;
      err_s     = 1'b0;
      grant_s   = grant_r;
      last_s    = last_r;
      case (state_r)
         IDLE: begin
            if (any_req_s) begin
               psel_s    = 1'b1;
               penable_s = 1'b0;
               grant_s   = win_s;
               pwrite_s  = write_i[win_s];
               paddr_s   = win_s ? addr1_i : addr0_i;
               pwdata_s  = win_s ? wdata1_i : wdata0_i;
            end else begin
               psel_s    = 1'b0;
               penable_s = 1'b0;
               pwrite_s  = 1'b0;
               paddr_s   = ADDR_ZERO;
               pwdata_s  = DATA_ZERO;
            end
         end
         SETUP: begin
            psel_s    = 1'b1;
            penable_s = 1'b1;
         end
         ACCESS: begin
            if (finish_s) begin
               psel_s          = 1'b0;
               penable_s       = 1'b0;
               pwrite_s        = 1'b0;
               paddr_s         = ADDR_ZERO;
               pwdata_s        = DATA_ZERO;
               done_s[grant_r] = 1'b1;
               err_s           = timeout_s ? 1'b1 : slverr_s;
               last_s          = grant_r;
               if (ready_s && !pwrite) begin
                  rdata_s = prdata;
               end else begin
                  rdata_s = rdata_o;
               end
            end else begin
               psel_s    = 1'b1;
               penable_s = 1'b1;
            end
         end
         default: begin
            psel_s    = 1'b0;
            penable_s = 1'b0;
            pwrite_s  = 1'b0;
            paddr_s   = ADDR_ZERO;
            pwdata_s  = DATA_ZERO;
         end
      endcase
   end

   // Output and arbitration registers; the last-served pointer resets so requester 0 wins the first tie.
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         psel    <= 1'b0;
         penable <= 1'b0;
         pwrite  <= 1'b0;
         paddr   <= ADDR_ZERO;
         pwdata  <= DATA_ZERO;
         rdata_o <= DATA_ZERO;
         done_o  <= 2'b00;
         err_o   <= 1'b0;
         grant_r <= 1'b0;
         last_r  <= 1'b1;
      end else begin
         psel    <= psel_s;
         penable <= penable_s;
         pwrite  <= pwrite_s;
         paddr   <= paddr_s;
         pwdata  <= pwdata_s;
         rdata_o <= rdata_s;
         done_o  <= done_s;
         err_o   <= err_s;
         grant_r <= grant_s;
         last_r  <= last_s;
      end
   end

endmodule
